gray_counter: RTL and testbench



---
 rtl/gray_counter.sv | 102 ++++++++++
 tb/tb_gray_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Purpose : WIDTH-bit up/down counter with registered binary and Gray outputs plus wrap pulse.
// Latency : 1 cycle from sampled inputs to bin/gray/wrap; reset is asynchronous and immediate.
// Backpr. : none; the counter steps on every clock where en (or load) is high.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (bin <= RESET_VALUE, gray <= Gray(RESET_VALUE))
//   en        count enable, one step per clock
//   up        direction when stepping: 1 = increment, 0 = decrement
//   load      synchronous load strobe, wins over en
//   load_bin  binary value to load
//   bin       registered binary count
//   gray      registered Gray code of bin (bin ^ (bin >> 1)), updated on the same edge
//   wrap      registered pulse marking a wrap-around
//
// Build option GRAY_COUNTER_SAT_EN: saturate at 0 / all-ones instead of wrapping;
// wrap then flags every enabled step that is blocked at a limit.

module gray_counter #(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RST_BIN  = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             at_top, at_bot;

    assign at_top = (bin_q == ALL_ONES);
    assign at_bot = (bin_q == ZERO);

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up) begin
                // wrap flags the step taken from the top limit, whether it
                // rolls over (default) or is held there (saturating build).
                wrap_d = at_top;
`ifdef GRAY_COUNTER_SAT_EN
                if (!at_top) begin
                    bin_d = bin_q + ONE;
                end
`else
                bin_d = bin_q + ONE;
`endif
            end else begin
                wrap_d = at_bot;
`ifdef GRAY_COUNTER_SAT_EN
                if (!at_bot) begin
                    bin_d = bin_q - ONE;
                end
`else
                bin_d = bin_q - ONE;
`endif
            end
        end
        // Gray is derived from the next binary value so both registers
        // update on the same edge and are never skewed.
        gray_d = to_gray(bin_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter (WIDTH = 4, RESET_VALUE = 5): directed steps followed
// by a randomized run, all compared against an arithmetic reference model.
module tb_gray_counter;

    localparam int W    = 4;
    localparam int RV   = 5;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_bin = '0;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    // reference model state
    int unsigned m_bin  = RV;
    bit          m_wrap = 1'b0;
    int unsigned prev_gray;
    bit          stepped;

    // standard reflected Gray sequence for 4 bits
    int gseq[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    gray_counter #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_bin(load_bin), .bin(bin), .gray(gray), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned g_of(input int unsigned b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".bin"},  32'(bin),  m_bin);
        check({tag, ".gray"}, 32'(gray), g_of(m_bin));
        check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    endtask

    // one clock edge: advance the model with the inputs held on that edge,
    // then compare shortly after the edge
    task automatic tick(input string tag);
        int unsigned old_bin;
        @(posedge clk);
        old_bin   = m_bin;
        prev_gray = g_of(m_bin);
        stepped   = 1'b0;
        if (load) begin
            m_bin  = 32'(load_bin);
            m_wrap = 1'b0;
        end else if (en) begin
            stepped = 1'b1;
            if (up) begin
                m_wrap = (old_bin == MAXV);
`ifdef GRAY_COUNTER_SAT_EN
                if (old_bin != MAXV) m_bin = old_bin + 1;
`else
                m_bin = (old_bin + 1) % (MAXV + 1);
`endif
            end else begin
                m_wrap = (old_bin == 0);
`ifdef GRAY_COUNTER_SAT_EN
                if (old_bin != 0) m_bin = old_bin - 1;
`else
                m_bin = (old_bin + MAXV) % (MAXV + 1);
`endif
            end
        end else begin
            m_wrap = 1'b0;
        end
        #1;
        check_all(tag);
        if (stepped && (m_bin != old_bin))
            check({tag, ".onebit"}, $countones(32'(gray) ^ prev_gray), 1);
    endtask

    initial begin
        int wraps;

        // reset visible before any clock edge
        rst = 1'b1;
        #1;
        m_bin = RV; m_wrap = 1'b0;
        check("rst.bin",  32'(bin),  5);
        check("rst.gray", 32'(gray), 7);
        check("rst.wrap", 32'(wrap), 0);
        #2 rst = 1'b0;

        // load 0 then full up sweep
        load = 1'b1; load_bin = '0;
        tick("load0");
        load = 1'b0; en = 1'b1; up = 1'b1;
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            tick("sweep");
            check("sweep.seq", 32'(gray), gseq[(i + 1) % 16]);
            if (wrap) wraps++;
        end
        check("sweep.wraps", wraps, 1);

        // down wrap
        en = 1'b0; load = 1'b1; load_bin = '0;
        tick("dload");
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick("down1");
        check("down1.bin",  32'(bin),  15);
        check("down1.gray", 32'(gray), 8);
        check("down1.wrap", 32'(wrap), 1);
        tick("down2");
        check("down2.bin",  32'(bin),  14);
        check("down2.wrap", 32'(wrap), 0);

        // load beats en
        load = 1'b1; en = 1'b1; up = 1'b1; load_bin = 4'd9;
        tick("ldprio");
        check("ldprio.bin",  32'(bin),  9);
        check("ldprio.gray", 32'(gray), 13);

        // count to 7, then asynchronous reset between edges, then hold
        load_bin = '0;
        tick("mload");
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 7; i++) tick("mcount");
        check("mcount.bin", 32'(bin), 7);
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_bin = RV; m_wrap = 1'b0;
        check("arst.bin",  32'(bin),  5);
        check("arst.gray", 32'(gray), 7);
        check("arst.wrap", 32'(wrap), 0);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) tick("hold");

        // direction reversal without a dead cycle
        en = 1'b1; up = 1'b1;
        tick("rev_up");
        up = 1'b0;
        tick("rev_dn");
        check("rev.bin", 32'(bin), 5);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            up       = $urandom_range(0, 1) != 0;
            load     = ($urandom_range(0, 11) == 0);
            load_bin = W'($urandom_range(0, MAXV));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
